// File: rtl/delta_sigma_pkg.sv
// Shared widths, order encoding and saturating arithmetic for the delta-sigma modulator.
package delta_sigma_pkg;

   localparam logic ORDER_1 = 1'b0;
   localparam logic ORDER_2 = 1'b1;

   function automatic int acc1_w(input int nb_bit);
      return nb_bit + 2;
   endfunction

   function automatic int acc2_w(input int nb_bit);
      return nb_bit + 4;
   endfunction

   // The 64-bit sum is exact for every accumulator width used here, so it
   // behaves as a one-bit-wider adder followed by a clamp to w bits.
   function automatic longint sat_add(input longint a, input longint b, input int w);
      longint sum;
      longint lim;
      sum = a + b;
      lim = longint'(1) <<< (w - 1);
      if (sum > lim - 1) begin
         return lim - 1;
      end
      if (sum < -lim) begin
         return -lim;
      end
      return sum;
   endfunction

   function automatic logic sat_hit(input longint a, input longint b, input int w);
      longint sum;
      longint lim;
      sum = a + b;
      lim = longint'(1) <<< (w - 1);
      return (sum > lim - 1) || (sum < -lim);
   endfunction

endpackage

// File: rtl/delta_sigma_chan.sv
// One modulator channel: sample hold register, 1st/2nd-order loop and sticky saturation flag.
module delta_sigma_chan
   import delta_sigma_pkg::*;
#(
   parameter int NB_BIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trig,
   input  logic              clr,
   input  logic              order,
   input  logic              clr_sat,
   input  logic              load,
   input  logic [NB_BIT-1:0] data,
   output logic              dac,
   output logic              sat
);

   localparam int     W1      = acc1_w(NB_BIT);
   localparam int     W2      = acc2_w(NB_BIT);
   localparam longint FB_FULL = longint'(1) <<< NB_BIT;

   logic [NB_BIT-1:0]    hold;
   logic signed [W1-1:0] acc1;
   logic signed [W1-1:0] acc1_n;
   logic signed [W2-1:0] acc2;
   logic signed [W2-1:0] acc2_n;
   logic                 y_n;
   logic                 clamp;
   logic                 hit1;
   logic                 hit2;
   longint               fb;
   longint               in1;
   longint               in2;

   // Feedback is the registered bit currently on the pin.
   always_comb begin
      fb     = dac ? FB_FULL : 64'sd0;
      in1    = longint'({1'b0, hold}) - fb;
      acc1_n = W1'(sat_add(longint'(acc1), in1, W1));
      hit1   = sat_hit(longint'(acc1), in1, W1);
      in2    = longint'(acc1_n) - fb;
      acc2_n = W2'(sat_add(longint'(acc2), in2, W2));
      hit2   = sat_hit(longint'(acc2), in2, W2);
      if (order == ORDER_2) begin
         y_n   = !acc2_n[W2-1] && (acc2_n != '0);
         clamp = hit1 || hit2;
      end else begin
         y_n   = !acc1_n[W1-1] && (acc1_n != '0);
         clamp = hit1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
         acc1 <= '0;
         acc2 <= '0;
         dac  <= 1'b0;
         sat  <= 1'b0;
      end else begin
         if (load) begin
            hold <= data;
         end
         if (clr) begin
            acc1 <= '0;
            acc2 <= '0;
            dac  <= 1'b0;
         end else if (trig) begin
            acc1 <= acc1_n;
            acc2 <= (order == ORDER_2) ? acc2_n : '0;
            dac  <= y_n;
         end
         // A new clamp wins over a coincident clear request.
         sat <= (trig && !clr && clamp) || (sat && !clr_sat);
      end
   end

endmodule

// File: rtl/delta_sigma_multi.sv
// Multi-channel delta-sigma DAC modulator: order register, order-change clearing and per-channel slicing.
module delta_sigma_multi
   import delta_sigma_pkg::*;
#(
   parameter int NB_BIT  = 16,
   parameter int NB_CHAN = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      trig_i,
   input  logic [NB_CHAN*NB_BIT-1:0] data_i,
   input  logic [NB_CHAN-1:0]        data_en_i,
   input  logic                      order_i,
   input  logic                      clr_sat_i,
   output logic [NB_CHAN-1:0]        dac_o,
   output logic [NB_CHAN-1:0]        sat_o
);

   logic order_q;
   logic order_chg;

   // A change seen on one edge clears every loop on the following edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         order_q   <= ORDER_1;
         order_chg <= 1'b0;
      end else begin
         order_q   <= order_i;
         order_chg <= (order_i != order_q);
      end
   end

   for (genvar k = 0; k < NB_CHAN; k++) begin : g_chan
      delta_sigma_chan #(
         .NB_BIT (NB_BIT)
      ) u_chan (
         .clk     (clk_i),
         .rst     (rst_i),
         .trig    (trig_i),
         .clr     (order_chg),
         .order   (order_q),
         .clr_sat (clr_sat_i),
         .load    (data_en_i[k]),
         .data    (data_i[k*NB_BIT +: NB_BIT]),
         .dac     (dac_o[k]),
         .sat     (sat_o[k])
      );
   end

endmodule

// File: tb/tb_delta_sigma_multi.sv
// Bench for delta_sigma_multi: a 4-bit two-channel instance and a 16-bit single-channel instance.
module tb_delta_sigma_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        trig;
   logic        order;
   logic        clr_sat;
   logic [7:0]  data;
   logic [1:0]  data_en;
   logic [1:0]  dac;
   logic [1:0]  sat;
   logic [15:0] w_data;
   logic [0:0]  w_data_en;
   logic [0:0]  w_dac;
   logic [0:0]  w_sat;

   int checks = 0;
   int errors = 0;
   logic [5:0] exp_q[$];

   // reference state: channels 0,1 are the 4-bit instance, channel 2 the 16-bit one
   longint m_acc1[3];
   longint m_acc2[3];
   longint m_hold[3];
   bit     m_dac[3];
   bit     m_sat[3];
   bit     m_ord;
   bit     m_chg;

   always #5 clk = ~clk;

   delta_sigma_multi #(.NB_BIT(4), .NB_CHAN(2)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .trig_i    (trig),
      .data_i    (data),
      .data_en_i (data_en),
      .order_i   (order),
      .clr_sat_i (clr_sat),
      .dac_o     (dac),
      .sat_o     (sat)
   );

   delta_sigma_multi #(.NB_BIT(16), .NB_CHAN(1)) dut_w (
      .clk_i     (clk),
      .rst_i     (rst),
      .trig_i    (trig),
      .data_i    (w_data),
      .data_en_i (w_data_en),
      .order_i   (order),
      .clr_sat_i (clr_sat),
      .dac_o     (w_dac),
      .sat_o     (w_sat)
   );

   function automatic longint clampv(input longint s, input int w, inout bit hit);
      longint lim;
      lim = longint'(1) <<< (w - 1);
      if (s > lim - 1) begin
         hit = 1'b1;
         return lim - 1;
      end
      if (s < -lim) begin
         hit = 1'b1;
         return -lim;
      end
      return s;
   endfunction

   task automatic model_step();
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_acc1[k] = 0; m_acc2[k] = 0; m_hold[k] = 0; m_dac[k] = 0; m_sat[k] = 0;
         end
         m_ord = 0;
         m_chg = 0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            int     n;
            bit     din;
            bit     hit;
            longint hin;
            longint fb;
            n   = (k == 2) ? 16 : 4;
            din = (k == 2) ? w_data_en[0] : data_en[k];
            hin = (k == 2) ? longint'(w_data) : longint'(data[k*4 +: 4]);
            hit = 0;
            if (m_chg) begin
               m_acc1[k] = 0; m_acc2[k] = 0; m_dac[k] = 0;
            end else if (trig) begin
               fb = m_dac[k] ? (longint'(1) <<< n) : 0;
               m_acc1[k] = clampv(m_acc1[k] + m_hold[k] - fb, n + 2, hit);
               if (m_ord) begin
                  m_acc2[k] = clampv(m_acc2[k] + m_acc1[k] - fb, n + 4, hit);
                  m_dac[k]  = (m_acc2[k] > 0);
               end else begin
                  m_acc2[k] = 0;
                  m_dac[k]  = (m_acc1[k] > 0);
               end
            end
            m_sat[k] = hit | (m_sat[k] & !clr_sat);
            if (din) m_hold[k] = hin;
         end
         m_chg = (order != m_ord);
         m_ord = order;
      end
      exp_q.push_back({m_sat[2], m_dac[2], m_sat[1], m_sat[0], m_dac[1], m_dac[0]});
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      logic [5:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({w_sat, w_dac, sat, dac} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got=%b expected=%b", $time, {w_sat, w_dac, sat, dac}, e);
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic idle();
      trig = 0; data_en = 0; w_data_en = 0; clr_sat = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      idle();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   initial begin
      int zeros0;
      int ones1;
      int ones;
      logic [1:0] sat_seen;
      rst = 1; order = 0; data = 0; w_data = 0;
      idle();
      repeat (3) @(negedge clk);
      check("reset_state", {w_sat, w_dac, sat, dac}, 0);
      rst = 0;

      // order 1: ch0 hold=4 gives 1,0,0,0 and ch1 hold=8 gives 1,0 at the same time
      data = {4'd8, 4'd4}; data_en = 2'b11; w_data = 16'h4000; w_data_en = 1;
      @(negedge clk);
      idle(); trig = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("pattern_o1", dac, {(i % 2) == 0, (i % 4) == 0});
      end
      idle();

      // hold=15: one 0 per 16 trigs; hold=0: constant 0, no saturation
      do_reset();
      data = {4'd0, 4'd15}; data_en = 2'b11;
      @(negedge clk);
      idle(); trig = 1;
      zeros0 = 0; ones1 = 0; sat_seen = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         zeros0 += int'(!dac[0]);
         ones1 += int'(dac[1]);
         sat_seen |= sat;
      end
      check("hold15_zeros", zeros0, 2);
      check("hold0_ones", ones1, 0);
      check("hold_sat", sat_seen, 0);
      idle();

      // load coincident with trig: old sample on that edge, new sample on the next trig
      do_reset();
      data = 8'h00; data_en = 2'b01;
      @(negedge clk);
      data = 8'h08; data_en = 2'b01; trig = 1;
      @(negedge clk);
      check("old_sample", dac[0], 0);
      data_en = 0;
      @(negedge clk);
      check("new_sample", dac[0], 1);
      idle();

      // order change mid-stream: cleared two edges later, trig on the clear edge ignored
      do_reset();
      data = {4'd8, 4'd15}; data_en = 2'b11; w_data = 16'h8000; w_data_en = 1;
      @(negedge clk);
      idle(); trig = 1;
      repeat (5) @(negedge clk);
      order = 1;
      @(negedge clk);
      @(negedge clk);
      check("order_clear", {w_dac, dac}, 0);
      @(negedge clk);
      check("order_resume", {w_dac, dac}, 3'b111);

      // asynchronous reset between edges forces outputs low at once
      #1 rst = 1;
      #1 check("async_reset", {w_sat, w_dac, sat, dac}, 0);
      idle();
      repeat (2) @(negedge clk);
      rst = 0;

      // near full scale in order 2 to provoke clamps, with random sticky-flag clears
      do_reset();
      data = 8'hff; data_en = 2'b11; w_data = 16'hffff; w_data_en = 1;
      @(negedge clk);
      idle(); trig = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         clr_sat = ($urandom_range(0, 7) == 0);
      end
      idle();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         trig = $urandom_range(0, 1);
         data = 8'($urandom);
         data_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         w_data = 16'($urandom);
         w_data_en = ($urandom_range(0, 3) == 0);
         clr_sat = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) order = !order;
      end
      idle();

      // order 2 density: hold=0x4000 over 65536 trigs
      order = 1;
      do_reset();
      w_data = 16'h4000; w_data_en = 1;
      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      trig = 1;
      ones = 0;
      repeat (65536) begin
         @(negedge clk);
         ones += int'(w_dac[0]);
      end
      checks++;
      if (ones < 16381 || ones > 16387) begin
         errors++;
         $display("FAIL density_o2 got=%0d expected=16384+-3", ones);
      end
      idle();

      repeat (2) @(negedge clk);
      #1 check("scoreboard_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
